ncl_mult_seq: RTL and testbench

- Parametrised, clocked successor to the team's 3×3 dual-rail NCL multiplier.
- Accepts WA-bit and WB-bit dual-rail operands under the NCL four-phase DATA/NULL handshake (Ki/Ko) and computes an unsigned or two's-complement product by iterative shift-add, one multiplier bit per cycle.
- Drives a registered dual-rail product toward the downstream NCL register stage.
- Replaces fixed combinational arrays wherever operand width exceeds 3 bits.

---
 rtl/ncl_mult_seq.sv | 109 ++++++++++
 tb/tb_ncl_mult_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/ncl_mult_seq.sv
// ncl_mult_seq: dual-rail NCL shift-add multiplier, one multiplier bit per clock,
// with a four-phase Ki/Ko DATA/NULL handshake and a registered dual-rail product.
module ncl_mult_seq #(
    parameter int WA     = 3,
    parameter int WB     = 3,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WA-1:0]   a_rail1,
    input  logic [WA-1:0]   a_rail0,
    input  logic [WB-1:0]   b_rail1,
    input  logic [WB-1:0]   b_rail0,
    input  logic            Ki,
    output logic [WA+WB-1:0] p_rail1,
    output logic [WA+WB-1:0] p_rail0,
    output logic            Ko,
    output logic            busy,
    output logic            err
);
    localparam int W  = WA + WB;
    localparam int CW = $clog2(WB);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_nx;
    logic [WA-1:0] a_q, a_nx;
    logic [WB-1:0] b_q, b_nx;
    logic [W-1:0]  acc, acc_nx, p1_nx, p0_nx, a_ext, term, sum;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ko_nx, busy_nx, err_nx, illegal, all_data, all_null, last;
    assign illegal  = |(a_rail1 & a_rail0) | |(b_rail1 & b_rail0);
    assign all_data = &(a_rail1 ^ a_rail0) & &(b_rail1 ^ b_rail0);
    assign all_null = ~|(a_rail1 | a_rail0) & ~|(b_rail1 | b_rail0);
    assign a_ext    = {{WB{(SIGNED != 0) && a_q[WA-1]}}, a_q};
    assign term     = a_ext << cnt;
    assign last     = cnt == CW'(WB - 1);
    // The MSB of a two's-complement multiplier carries negative weight.
    assign sum      = !b_q[cnt] ? acc : ((SIGNED != 0) && last) ? acc - term : acc + term;
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        acc_nx   = acc;
        cnt_nx   = cnt;
        p1_nx    = p_rail1;
        p0_nx    = p_rail0;
        ko_nx    = Ko;
        busy_nx  = busy;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (illegal) begin
                    err_nx = 1'b1;
                end else if (all_data && Ki) begin
                    a_nx     = a_rail1;
                    b_nx     = b_rail1;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    ko_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = MUL;
                end
            end
            MUL: begin
                acc_nx = sum;
                cnt_nx = cnt + 1'b1;
                if (last) begin
                    p1_nx    = sum;
                    p0_nx    = ~sum;
                    busy_nx  = 1'b0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!Ki && all_null) begin
                    p1_nx    = '0;
                    p0_nx    = '0;
                    ko_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            p_rail1 <= '0;
            p_rail0 <= '0;
            Ko      <= 1'b1;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            acc     <= acc_nx;
            cnt     <= cnt_nx;
            p_rail1 <= p1_nx;
            p_rail0 <= p0_nx;
            Ko      <= ko_nx;
            busy    <= busy_nx;
            err     <= err_nx;
        end
    end
endmodule

// File: tb/tb_ncl_mult_seq.sv
// tb_ncl_mult_seq: directed checks of the unsigned 3x3 and signed 4x4 NCL multiplier.
module tb_ncl_mult_seq;
    logic clk = 0, rst = 1;
    logic [2:0] a1 = 0, a0 = 0, b1 = 0, b0 = 0;
    logic [5:0] p1, p0;
    logic ki = 0, ko, busy, err;
    logic [3:0] c1 = 0, c0 = 0, d1 = 0, d0 = 0;
    logic [7:0] q1, q0;
    logic ki2 = 0, ko2, busy2, err2;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    ncl_mult_seq dut (.clk(clk), .rst(rst), .a_rail1(a1), .a_rail0(a0), .b_rail1(b1), .b_rail0(b0),
        .Ki(ki), .p_rail1(p1), .p_rail0(p0), .Ko(ko), .busy(busy), .err(err));
    ncl_mult_seq #(.WA(4), .WB(4), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .a_rail1(c1), .a_rail0(c0),
        .b_rail1(d1), .b_rail0(d0), .Ki(ki2), .p_rail1(q1), .p_rail0(q0), .Ko(ko2), .busy(busy2), .err(err2));
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_ab(input logic [2:0] a, input logic [2:0] b);
        a1 = a; a0 = ~a; b1 = b; b0 = ~b;
    endtask
    task automatic go_null();
        ki = 0; a1 = 0; a0 = 0; b1 = 0; b0 = 0;
        tick(1);
        tests++; if (p1 !== 6'd0 || p0 !== 6'd0 || ko !== 1'b1) begin fails++; $display("FAIL null_phase p1=%b p0=%b ko=%b want 0 0 1", p1, p0, ko); end
    endtask
    task automatic test_reset();
        rst = 1; tick(2);
        tests++; if (p1 !== 6'd0 || p0 !== 6'd0 || ko !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset p1=%b p0=%b ko=%b busy=%b err=%b want 0 0 1 0 0", p1, p0, ko, busy, err); end
        tests++; if (q1 !== 8'd0 || q0 !== 8'd0 || ko2 !== 1'b1 || busy2 !== 1'b0 || err2 !== 1'b0) begin fails++; $display("FAIL reset_s q1=%h q0=%h ko=%b busy=%b err=%b", q1, q0, ko2, busy2, err2); end
        rst = 0;
    endtask
    task automatic test_basic();
        set_ab(3'd5, 3'd7); ki = 1;
        tick(1);
        tests++; if (ko !== 1'b0 || busy !== 1'b1 || p1 !== 6'd0) begin fails++; $display("FAIL capture ko=%b busy=%b p1=%b want 0 1 0", ko, busy, p1); end
        tick(1);
        tests++; if (p1 !== 6'd0 || p0 !== 6'd0 || ko !== 1'b0) begin fails++; $display("FAIL early_p p1=%b p0=%b ko=%b want NULL ko 0", p1, p0, ko); end
        tick(1);
        tests++; if (p1 !== 6'd0 || p0 !== 6'd0) begin fails++; $display("FAIL early_p2 p1=%b p0=%b want NULL", p1, p0); end
        tick(1);
        tests++; if (p1 !== 6'b100011 || p0 !== 6'b011100 || busy !== 1'b0 || ko !== 1'b0) begin fails++; $display("FAIL prod_5x7 p1=%b p0=%b busy=%b ko=%b want 100011 011100 0 0", p1, p0, busy, ko); end
        ki = 0; tick(1);
        tests++; if (p1 !== 6'b100011 || ko !== 1'b0) begin fails++; $display("FAIL hold_data p1=%b ko=%b want 100011 0", p1, ko); end
        go_null();
    endtask
    task automatic test_back_to_back();
        set_ab(3'd7, 3'd7); ki = 1; tick(4);
        tests++; if (p1 !== 6'b110001 || p0 !== 6'b001110) begin fails++; $display("FAIL prod_7x7 p1=%b p0=%b want 110001 001110", p1, p0); end
        go_null();
        set_ab(3'd0, 3'd5); ki = 1; tick(4);
        tests++; if (p1 !== 6'd0 || p0 !== 6'b111111 || ko !== 1'b0) begin fails++; $display("FAIL prod_0x5 p1=%b p0=%b ko=%b want 000000 111111 0", p1, p0, ko); end
        go_null();
    endtask
    task automatic test_signed();
        c1 = 4'b1101; c0 = ~c1; d1 = 4'b0101; d0 = ~d1; ki2 = 1;
        tick(4);
        tests++; if (q1 !== 8'd0 || busy2 !== 1'b1) begin fails++; $display("FAIL signed_early q1=%h busy=%b want 00 1", q1, busy2); end
        tick(1);
        tests++; if (q1 !== 8'hF1 || q0 !== 8'h0E) begin fails++; $display("FAIL prod_m3x5 q1=%h q0=%h want f1 0e", q1, q0); end
        ki2 = 0; c1 = 0; c0 = 0; d1 = 0; d0 = 0; tick(1);
        tests++; if (q1 !== 8'd0 || ko2 !== 1'b1) begin fails++; $display("FAIL signed_null q1=%h ko=%b want 00 1", q1, ko2); end
        c1 = 4'b1000; c0 = ~c1; d1 = 4'b1000; d0 = ~d1; ki2 = 1;
        tick(5);
        tests++; if (q1 !== 8'h40 || q0 !== 8'hBF) begin fails++; $display("FAIL prod_m8xm8 q1=%h q0=%h want 40 bf", q1, q0); end
        ki2 = 0; c1 = 0; c0 = 0; d1 = 0; d0 = 0; tick(1);
    endtask
    task automatic test_incomplete();
        a1 = 3'd5; a0 = 3'd2; b1 = 3'b001; b0 = 3'b100; ki = 1;
        tick(1);
        tests++; if (ko !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL partial ko=%b busy=%b want 1 0", ko, busy); end
        set_ab(3'd5, 3'd3); ki = 0; tick(2);
        tests++; if (ko !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ki_low ko=%b busy=%b want 1 0", ko, busy); end
        ki = 1; tick(1);
        tests++; if (ko !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL late_cap ko=%b busy=%b want 0 1", ko, busy); end
        tick(3);
        tests++; if (p1 !== 6'b001111 || p0 !== 6'b110000) begin fails++; $display("FAIL prod_5x3 p1=%b p0=%b want 001111 110000", p1, p0); end
        go_null();
    endtask
    task automatic test_illegal();
        a1 = 3'd2; a0 = 3'd5; b1 = 3'b011; b0 = 3'b101; ki = 1;
        tick(1);
        tests++; if (err !== 1'b1 || busy !== 1'b0 || ko !== 1'b1) begin fails++; $display("FAIL illegal err=%b busy=%b ko=%b want 1 0 1", err, busy, ko); end
        set_ab(3'd2, 3'd3); tick(4);
        tests++; if (p1 !== 6'd6 || err !== 1'b1) begin fails++; $display("FAIL err_sticky p1=%b err=%b want 000110 1", p1, err); end
        go_null();
    endtask
    task automatic test_reset_mid();
        set_ab(3'd3, 3'd6); ki = 1; tick(2);
        rst = 1; tick(1); rst = 0;
        tests++; if (busy !== 1'b0 || ko !== 1'b1 || p1 !== 6'd0 || p0 !== 6'd0 || err !== 1'b0) begin fails++; $display("FAIL rst_mid busy=%b ko=%b p1=%b p0=%b err=%b want 0 1 0 0 0", busy, ko, p1, p0, err); end
        tick(1);
        tests++; if (busy !== 1'b1 || ko !== 1'b0) begin fails++; $display("FAIL recap busy=%b ko=%b want 1 0", busy, ko); end
        tick(3);
        tests++; if (p1 !== 6'b010010 || p0 !== 6'b101101) begin fails++; $display("FAIL prod_3x6 p1=%b p0=%b want 010010 101101", p1, p0); end
        go_null();
    endtask
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_signed();
        test_incomplete();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
